fft_result_serializer: RTL
==========================

Name: fft_result_serializer

Overview:
- Sits on the output side of the FFT core and consumes its result interface.
- The core presents 16 parallel 16-bit lanes per fft_valid beat: real parts first, then imaginary parts for the same 16 points.
- This block buffers each real/imag beat pair and re-emits it as a serial stream of complex points, one per ready/valid handshake, with a point index and frame markers.
- It feeds downstream magnitude/storage logic that cannot accept 16-wide data.

Parameters:
- DATA_W, 16, width of each real/imag word (8 integer + 8 fraction, two's complement).
- LANES, 16, points delivered per fft_valid beat pair.
- FRAME_PTS, 1024, complex points per FFT frame.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- fft_valid  input  1  result beat present on fft_d0..fft_d15 this cycle.
- fft_d0..fft_d15  input  16 each  lane k = point k of the current group; real on a group's first beat, imag on its second.
- out_valid  output  1  out_re/out_im/out_idx/out_last valid.
- out_ready  input  1  downstream accepts the point this cycle.
- out_re  output  16  real part of the current point.
- out_im  output  16  imaginary part of the current point.
- out_idx  output  10  frame point index, 0..FRAME_PTS-1.
- out_last  output  1  high with the point at out_idx = FRAME_PTS-1.
- frame_done  output  1  one-cycle pulse after the last point of a frame is accepted.
- overflow  output  1  sticky: a beat pair was dropped because no bank was free.

Behaviour:
- Reset (rst low, async): all outputs 0, both banks empty, phase = REAL, write and read bank pointers = 0, point counter = 0. Reset mid-frame discards all buffered data.
- Phase toggle: each fft_valid beat flips the phase REAL -> IMAG -> REAL. Any number of idle cycles between beats is legal.
- Two ping-pong banks, each holding LANES complex entries.
- REAL beat: if the write bank is empty, capture the 16 lanes into its real half. Otherwise set overflow and mark the pair as dropped; the following IMAG beat is also discarded.
- IMAG beat (pair not dropped): capture the imag half, mark the bank full, advance the write pointer.
- Read FSM, two states:
  - IDLE -> DRAIN when the read bank is full.
  - DRAIN presents lane 0..15 in order.
  - On out_valid && out_ready: advance the lane; at lane 15, mark the bank empty, advance the read pointer, and go to IDLE (or stay in DRAIN if the other bank is already full).
- Latency: out_valid rises the cycle after the IMAG beat is captured into an empty-read-side bank.
- Throughput: one point per cycle when out_ready is held high.
- While out_valid && !out_ready, out_re/out_im/out_idx/out_last hold stable.
- out_idx increments per accepted point and wraps from 1023 to 0. out_last = (out_idx == FRAME_PTS-1).
- frame_done pulses one cycle after the out_last handshake.
- Simultaneous events: if the final drain handshake of a bank and a REAL beat targeting that same bank occur in the same cycle, the beat is accepted (empty status is evaluated with the freeing included) and no overflow is raised.
- overflow clears only on reset. Dropped points do not advance out_idx.
- No arithmetic: data passes through bit-exact.

Decomposition:
- Shared package fft_pkg: DATA_W, LANES, FRAME_PTS, IDX_W = $clog2(FRAME_PTS), and a typedef cplx_t (struct of re/im, DATA_W each), shared with the FFT core.
- One sub-module fft_bank: a 16-entry cplx_t store with real-half write, imag-half write, lane read, and full/empty flag.
- The top instantiates two fft_bank instances plus the phase logic and read FSM.

Test Plan:
- Single group: REAL beat lanes = 16'h0100*k, IMAG beat lanes = 16'hFF00-k, out_ready=1 -> out_valid one cycle after IMAG; 16 consecutive points with out_re=16'h0100*k, out_im=16'hFF00-k, out_idx 0..15.
- Backpressure: same group, out_ready toggling 1,0,0,1 -> each point held stable while stalled, 16 points delivered exactly once, no duplicates.
- Full frame: 64 groups back-to-back (128 beats), out_ready=1 -> 1024 points, out_last only at idx 1023, frame_done pulse one cycle later, out_idx wraps to 0 on the next group.
- Overflow: out_ready=0 while 3 groups arrive -> groups 0 and 1 buffered, group 2 dropped, overflow=1 and stays 1; after releasing out_ready, exactly 32 points emitted (idx 0..31).
- Free-and-refill same cycle: time a REAL beat to coincide with the lane-15 handshake of the bank it targets -> accepted, overflow remains 0.
- Reset mid-drain: assert rst at lane 7 -> all outputs 0 immediately; a new group after release starts at out_idx=0 with phase REAL.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT result path; also used by the FFT core.
package fft_pkg;

  localparam int DATA_W    = 16;
  localparam int LANES     = 16;
  localparam int FRAME_PTS = 1024;
  localparam int IDX_W     = $clog2(FRAME_PTS);
  localparam int LANE_W    = $clog2(LANES);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {PH_REAL, PH_IMAG}  phase_e;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

endpackage

// File: rtl/fft_bank.sv
// One ping-pong bank: LANES complex entries, real and imag halves written by
// separate beats, read one lane at a time, with a full flag.
module fft_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_re,
  input  logic              wr_im,
  input  logic              clr,
  input  logic [DATA_W-1:0] din [LANES],
  input  logic [LANE_W-1:0] rd_lane,
  output cplx_t             rd_data,
  output logic              full
);

  cplx_t mem [LANES];

  // NOTE: the data store has no reset; nothing reads it until full is set,
  // so only the flag needs one.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_re) mem[k].re <= din[k];
      if (wr_im) mem[k].im <= din[k];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       full <= 1'b0;
    else if (wr_im) full <= 1'b1;
    else if (clr)   full <= 1'b0;
  end

  assign rd_data = mem[rd_lane];

endmodule

// File: rtl/fft_result_serializer.sv
// Buffers REAL/IMAG beat pairs from the FFT core into two ping-pong banks and
// streams them out one complex point per ready/valid handshake.
module fft_result_serializer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [DATA_W-1:0] fft_d0,
  input  logic [DATA_W-1:0] fft_d1,
  input  logic [DATA_W-1:0] fft_d2,
  input  logic [DATA_W-1:0] fft_d3,
  input  logic [DATA_W-1:0] fft_d4,
  input  logic [DATA_W-1:0] fft_d5,
  input  logic [DATA_W-1:0] fft_d6,
  input  logic [DATA_W-1:0] fft_d7,
  input  logic [DATA_W-1:0] fft_d8,
  input  logic [DATA_W-1:0] fft_d9,
  input  logic [DATA_W-1:0] fft_d10,
  input  logic [DATA_W-1:0] fft_d11,
  input  logic [DATA_W-1:0] fft_d12,
  input  logic [DATA_W-1:0] fft_d13,
  input  logic [DATA_W-1:0] fft_d14,
  input  logic [DATA_W-1:0] fft_d15,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow
);

  logic [DATA_W-1:0] lanes [LANES];
  cplx_t             bank_data [2];
  logic [1:0]        full;

  phase_e            phase;
  rd_state_e         state;
  logic              dropped;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [LANE_W-1:0] lane;

  logic accept, last_lane, drain_free, wr_free, real_wr, imag_wr;
  logic cur_ready, nxt_ready;

  assign lanes = '{fft_d0, fft_d1, fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  assign accept     = out_valid && out_ready;
  assign last_lane  = (lane == LANE_W'(LANES-1));
  assign drain_free = accept && last_lane;
  // A bank finishing its drain this cycle counts as free for an incoming REAL beat.
  assign wr_free    = !full[wr_ptr] || (drain_free && (rd_ptr == wr_ptr));
  assign real_wr    = fft_valid && (phase == PH_REAL) && wr_free;
  assign imag_wr    = fft_valid && (phase == PH_IMAG) && !dropped;
  assign cur_ready  = full[rd_ptr]  || (imag_wr && (wr_ptr == rd_ptr));
  assign nxt_ready  = full[~rd_ptr] || (imag_wr && (wr_ptr != rd_ptr));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_re   (real_wr && (wr_ptr == 1'(b))),
      .wr_im   (imag_wr && (wr_ptr == 1'(b))),
      .clr     (drain_free && (rd_ptr == 1'(b))),
      .din     (lanes),
      .rd_lane (lane),
      .rd_data (bank_data[b]),
      .full    (full[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= PH_REAL;
      dropped  <= 1'b0;
      wr_ptr   <= 1'b0;
      overflow <= 1'b0;
    end else if (fft_valid) begin
      if (phase == PH_REAL) begin
        phase   <= PH_IMAG;
        dropped <= !wr_free;
        if (!wr_free) overflow <= 1'b1;
      end else begin
        phase <= PH_REAL;
        if (!dropped) wr_ptr <= ~wr_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RD_IDLE;
      rd_ptr     <= 1'b0;
      lane       <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && out_last;
      case (state)
        RD_IDLE: begin
          if (cur_ready) begin
            state     <= RD_DRAIN;
            out_valid <= 1'b1;
            lane      <= '0;
          end
        end
        RD_DRAIN: begin
          if (accept) begin
            out_idx <= (out_idx == IDX_W'(FRAME_PTS-1)) ? '0 : out_idx + 1'b1;
            if (last_lane) begin
              rd_ptr <= ~rd_ptr;
              lane   <= '0;
              if (!nxt_ready) begin
                state     <= RD_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  // Gate data with valid so the outputs read zero out of reset.
  assign out_re   = out_valid ? bank_data[rd_ptr].re : '0;
  assign out_im   = out_valid ? bank_data[rd_ptr].im : '0;
  assign out_last = out_valid && (out_idx == IDX_W'(FRAME_PTS-1));

endmodule
